pcap_mem_load: RTL

Read-side counterpart of the pcap store path in the OSNT SUME external-memory pcap replay engine. Accepts four AXI4-Stream packet streams read back from external memory, one per replay queue. Merges them packet-atomically, with round-robin fairness, onto a single master stream toward the output port lookup. Stamps each packet's destination-port field with the physical port for its queue and counts the packets emitted per queue.

---
 rtl/pcap_mem_load.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pcap_mem_load.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcap_mem_load
// Purpose  : Packet-atomic round-robin merge of four replay queues onto one
//            AXI4-Stream master, with destination-port stamping and counters.
// Revision : 1.0 - initial release
// ============================================================================
module pcap_mem_load #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = 24,
    parameter int NUM_QUEUES           = 4
) (
    input  logic                              axis_aclk,
    input  logic                              axis_aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    output logic                              s0_axis_tready,
    input  logic                              s0_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    output logic                              s1_axis_tready,
    input  logic                              s1_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s2_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s2_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s2_axis_tuser,
    input  logic                              s2_axis_tvalid,
    output logic                              s2_axis_tready,
    input  logic                              s2_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s3_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s3_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s3_axis_tuser,
    input  logic                              s3_axis_tvalid,
    output logic                              s3_axis_tready,
    input  logic                              s3_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic [3:0]                        replay_en,
    input  logic                              cnt_clear,
    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1,
    output logic [31:0]                       pkt_cnt_2,
    output logic [31:0]                       pkt_cnt_3
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_rr_ptr;
    logic [31:0] r_pkt_cnt [NUM_QUEUES];

    logic [3:0]                         w_valid;
    logic [3:0]                         w_last;
    logic [3:0]                         w_cand;
    logic [3:0]                         w_ready;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     w_data [NUM_QUEUES];
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   w_keep [NUM_QUEUES];
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    w_user [NUM_QUEUES];
    logic                               w_found;
    logic [1:0]                         w_pick;
    logic                               w_send;
    logic                               w_xfer;
    logic                               w_eop;

    assign w_valid = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign w_last  = {s3_axis_tlast,  s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};
    assign w_cand  = w_valid & replay_en;

    assign w_data[0] = s0_axis_tdata;
    assign w_data[1] = s1_axis_tdata;
    assign w_data[2] = s2_axis_tdata;
    assign w_data[3] = s3_axis_tdata;
    assign w_keep[0] = s0_axis_tkeep;
    assign w_keep[1] = s1_axis_tkeep;
    assign w_keep[2] = s2_axis_tkeep;
    assign w_keep[3] = s3_axis_tkeep;
    assign w_user[0] = s0_axis_tuser;
    assign w_user[1] = s1_axis_tuser;
    assign w_user[2] = s2_axis_tuser;
    assign w_user[3] = s3_axis_tuser;

    // Scan from the farthest offset down so the offset closest to rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (w_cand[r_rr_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_pick  = r_rr_ptr + 2'(i);
            end
        end
    end

    assign w_send  = (r_state == ST_SEND);
    assign w_xfer  = w_send & w_valid[r_grant] & m_axis_tready;
    assign w_eop   = w_xfer & w_last[r_grant];
    assign w_ready = (w_send & m_axis_tready) ? (4'b0001 << r_grant) : 4'b0000;

    assign s0_axis_tready = w_ready[0];
    assign s1_axis_tready = w_ready[1];
    assign s2_axis_tready = w_ready[2];
    assign s3_axis_tready = w_ready[3];

    // Port codes are one-hot on even bits: q0=01, q1=04, q2=10, q3=40.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (w_send) begin
            m_axis_tdata  = w_data[r_grant];
            m_axis_tkeep  = w_keep[r_grant];
            m_axis_tuser  = w_user[r_grant];
            m_axis_tuser[DST_PORT_POS +: 8] = 8'h01 << {r_grant, 1'b0};
            m_axis_tvalid = w_valid[r_grant];
            m_axis_tlast  = w_last[r_grant];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_eop) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= r_grant + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an end-of-packet discards that increment.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int i = 0; i < NUM_QUEUES; i++) r_pkt_cnt[i] <= 32'd0;
        end else if (cnt_clear) begin
            for (int i = 0; i < NUM_QUEUES; i++) r_pkt_cnt[i] <= 32'd0;
        end else if (w_eop) begin
            r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
        end
    end

    assign pkt_cnt_0 = r_pkt_cnt[0];
    assign pkt_cnt_1 = r_pkt_cnt[1];
    assign pkt_cnt_2 = r_pkt_cnt[2];
    assign pkt_cnt_3 = r_pkt_cnt[3];

endmodule
`default_nettype wire
